led_pattern_gen: RTL
====================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, board clock frequency (documentation only, no logic).
REQ-002 SHALL have parameter TICK_DIV, default 50000000, clock cycles per pattern tick (>=2).
REQ-003 SHALL have parameter N_LEDS, default 8, number of LED outputs (>=1).
REQ-004 SHALL have parameter PWM_BITS, default 8, breathe duty/PWM resolution.
REQ-005 SHALL have port clock_50  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port mode  in  2  pattern select: 0 BLINK, 1 CHASE, 2 BOUNCE, 3 BREATHE.
REQ-008 SHALL have port pause  in  1  high freezes prescaler and pattern state.
REQ-009 SHALL have port LEDG  out  N_LEDS  registered LED drive, active-high, bit 0 first in chase.
REQ-010 SHALL have port tick  out  1  one-cycle pulse per pattern step.

Function
REQ-011 Prescaler SHALL count 0..TICK_DIV-1; tick high for the one cycle count==TICK_DIV-1, count wraps to 0 on the next cycle.
REQ-012 pause high SHALL hold prescaler, pattern state and tick low; PWM counter keeps running.
REQ-013 Pattern state SHALL advance only in cycles where tick is high; LEDG reflects the new state one cycle later.
REQ-014 BLINK: single bit, initial 1; toggles per tick; LEDG = all bits equal to it.
REQ-015 CHASE: one-hot position pos, initial 0; per tick pos = pos+1, wrapping N_LEDS-1 -> 0.
REQ-016 BOUNCE: pos initial 0, dir initial up; per tick move one step; at pos N_LEDS-1 dir becomes down, at pos 0 dir becomes up, reversal and step in same tick (sequence 0,1,..,N-1,N-2,..,0,1..); N_LEDS=1 holds pos 0.
REQ-017 BREATHE: duty (PWM_BITS) initial 0, dir up; per tick duty +1 until 2^PWM_BITS-1, then -1 until 0, turning at endpoints without repeating them; free-running PWM counter increments every clock; LEDG = all bits equal to (pwm_cnt < duty).
REQ-018 Duty 0 SHALL give LEDs fully off; duty max gives on for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
REQ-019 A mode change (mode != registered previous mode) SHALL, in that cycle, clear prescaler and load the new mode's initial state; no tick that cycle; applies even while pause is high.
REQ-020 Mode change and tick in the same cycle: mode change SHALL win.

Reset
REQ-021 While reset is high at a clock edge: prescaler 0, pwm counter 0, pos 0, dir up, duty 0, blink bit 1, mode register = mode input, tick 0, LEDG = pattern initial value for current mode (BLINK all 1, CHASE/BOUNCE bit0 only, BREATHE all 0).
REQ-022 Reset SHALL override pause and mode change; first tick occurs TICK_DIV cycles after reset deasserts.

Structure
REQ-023 Mode encodings (MODE_BLINK..MODE_BREATHE) SHALL live in shared package led_pkg.
REQ-024 Prescaler SHALL be a sub-module tick_gen (parameter TICK_DIV; ports clock_50, reset, clear, enable, tick).
REQ-025 Counter widths SHALL derive from parameters via $clog2; no fixed 32-bit counters.

Verification (TICK_DIV=4, N_LEDS=4, PWM_BITS=3)
REQ-026 Reset, mode=0 -> LEDG=1111; tick at cycles 4,8; LEDG 0000 after first tick, 1111 after second.
REQ-027 mode=1, 5 ticks -> LEDG 0001,0010,0100,1000,0001,0010.
REQ-028 mode=2, 7 ticks -> LEDG 0001,0010,0100,1000,0100,0010,0001,0010.
REQ-029 mode=3, after 7 ticks duty=7 -> LEDG high 7 of every 8 cycles; after 14 ticks duty=0 -> LEDG constant 0000.
REQ-030 mode=1, pause high for 20 cycles after 2 ticks -> LEDG stays 0100, tick 0; release -> next tick after 4 cycles, LEDG 1000.
REQ-031 Switch mode 1->2 in same cycle tick would fire -> no tick, LEDG 0001 next cycle, next tick 4 cycles later.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: pattern mode encodings,
// sweep direction and a width helper for index counters.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Width needed to index n items; a single item still needs one bit.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pattern_gen_tick_gen.sv
// Pattern-step prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick
// for the single cycle it sits at the last count.
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clock_50,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;
  logic             at_last;

  assign at_last = (count == CNT_LAST);
  // clear (a mode change) suppresses the pulse even when the count is at its end
  assign tick    = at_last && enable && !clear && !reset;

  always_ff @(posedge clock_50) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= at_last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: blink, chase, bounce and PWM breathe patterns stepped
// by a prescaled tick, with pause and glitch-free restart on mode change.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_DIV = 50000000,
  parameter int N_LEDS   = 8,
  parameter int PWM_BITS = 8
) (
  input  logic              clock_50,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              pause,
  output logic [N_LEDS-1:0] LEDG,
  output logic              tick
);

  localparam int POS_W = index_width(N_LEDS);
  localparam logic [POS_W-1:0]    POS_LAST = POS_W'(N_LEDS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [N_LEDS-1:0]   LED_ONE  = N_LEDS'(1);

  if (CLK_HZ < 1 || TICK_DIV < 2 || N_LEDS < 1 || PWM_BITS < 1) begin : g_bad_params
    $error("led_pattern_gen: illegal parameter values");
  end

  mode_e             mode_in;
  mode_e             mode_q;
  logic              mode_change;

  logic [POS_W-1:0]    pos_q,   pos_n;
  dir_e                dir_q,   dir_n;
  logic [PWM_BITS-1:0] duty_q,  duty_n;
  logic [PWM_BITS-1:0] pwm_q,   pwm_n;
  logic                blink_q, blink_n;

  assign mode_in     = mode_e'(mode);
  assign mode_change = (mode_in != mode_q);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clock_50(clock_50),
    .reset   (reset),
    .clear   (mode_change),
    .enable  (!pause),
    .tick    (tick)
  );

  function automatic logic [N_LEDS-1:0] pattern(
    input mode_e            m,
    input logic             blink,
    input logic [POS_W-1:0] pos,
    input logic             pwm_on
  );
    logic [N_LEDS-1:0] leds;
    case (m)
      MODE_BLINK:   leds = {N_LEDS{blink}};
      MODE_CHASE:   leds = LED_ONE << pos;
      MODE_BOUNCE:  leds = LED_ONE << pos;
      MODE_BREATHE: leds = {N_LEDS{pwm_on}};
      default:      leds = '0;
    endcase
    return leds;
  endfunction

  // Next pattern state. A mode change restarts every pattern from its initial
  // value; only the PWM counter keeps free-running.
  always_comb begin
    pos_n   = pos_q;
    dir_n   = dir_q;
    duty_n  = duty_q;
    blink_n = blink_q;
    pwm_n   = pwm_q + 1'b1;
    if (mode_change) begin
      pos_n   = '0;
      dir_n   = DIR_UP;
      duty_n  = '0;
      blink_n = 1'b1;
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK: begin
          blink_n = ~blink_q;
        end
        MODE_CHASE: begin
          pos_n = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        end
        MODE_BOUNCE: begin
          // A single LED has nowhere to move, so it simply stays lit.
          if (N_LEDS > 1) begin
            if (dir_q == DIR_UP) begin
              if (pos_q == POS_LAST) begin
                dir_n = DIR_DOWN;
                pos_n = pos_q - 1'b1;
              end else begin
                pos_n = pos_q + 1'b1;
              end
            end else begin
              if (pos_q == '0) begin
                dir_n = DIR_UP;
                pos_n = pos_q + 1'b1;
              end else begin
                pos_n = pos_q - 1'b1;
              end
            end
          end
        end
        MODE_BREATHE: begin
          if (dir_q == DIR_UP) begin
            if (duty_q == DUTY_MAX) begin
              dir_n  = DIR_DOWN;
              duty_n = duty_q - 1'b1;
            end else begin
              duty_n = duty_q + 1'b1;
            end
          end else begin
            if (duty_q == '0) begin
              dir_n  = DIR_UP;
              duty_n = duty_q + 1'b1;
            end else begin
              duty_n = duty_q - 1'b1;
            end
          end
        end
        default: begin
          pos_n = pos_q;
        end
      endcase
    end
  end

  // LEDG is registered from the next state, so it always shows the pattern
  // state held in the registers during the same cycle.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      duty_q  <= '0;
      blink_q <= 1'b1;
      pwm_q   <= '0;
      mode_q  <= mode_in;
      LEDG    <= pattern(mode_in, 1'b1, '0, 1'b0);
    end else begin
      pos_q   <= pos_n;
      dir_q   <= dir_n;
      duty_q  <= duty_n;
      blink_q <= blink_n;
      pwm_q   <= pwm_n;
      mode_q  <= mode_in;
      LEDG    <= pattern(mode_in, blink_n, pos_n, pwm_n < duty_n);
    end
  end

endmodule
